// File: rtl/fan_duty_sequencer.sv
// fan_duty_sequencer
//   Converts a 2-bit fan stage request into an 8-bit PWM duty (0..99) that
//   ramps one step per ramp tick. It also runs a sleep/off timer that forces
//   the fan to stop when it expires.
// Ports
//   clk         system clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   stage_req   requested stage: 0=STOP 1=LOW 2=HIGH 3=MAX
//   timer_btn   one-cycle pulse, cycles the timer setting
//   duty        PWM duty to the PWM generator, 0..99
//   fan_on      1 when duty != 0, registered together with duty
//   stage_eff   effective stage (0 while timeout is set)
//   timer_sel   0=OFF 1=1h 2=3h 3=5h
//   remain_sec  seconds left on the timer
//   timeout     latched timer expiry, fan forced off
module fan_duty_sequencer #(
  parameter int unsigned SEC_CYCLES  = 100_000_000,
  parameter int unsigned RAMP_CYCLES = 1_000_000,
  parameter int unsigned DUTY_LOW    = 33,
  parameter int unsigned DUTY_HIGH   = 66,
  parameter int unsigned DUTY_MAX    = 99
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  stage_req,
  input  logic        timer_btn,
  output logic [7:0]  duty,
  output logic        fan_on,
  output logic [1:0]  stage_eff,
  output logic [1:0]  timer_sel,
  output logic [14:0] remain_sec,
  output logic        timeout
);

  localparam int unsigned RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int unsigned SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  typedef enum logic [1:0] {ST_STOP, ST_RAMP, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic          fan_on_q;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [14:0]   remain_q, remain_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    stage_eff_w;
  logic [7:0]    target;
  logic          ramp_tick;
  logic          count_en;
  logic          sec_tick;
  logic [1:0]    sel_inc;

  assign stage_eff_w = timeout_q ? 2'd0 : stage_req;

  always_comb begin
    case (stage_eff_w)
      2'd1:    target = 8'(DUTY_LOW);
      2'd2:    target = 8'(DUTY_HIGH);
      2'd3:    target = 8'(DUTY_MAX);
      default: target = 8'd0;
    endcase
  end

  assign ramp_tick = (state_q == ST_RAMP) && (ramp_cnt_q == RW'(RAMP_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_STOP;
      duty_q     <= '0;
      fan_on_q   <= 1'b0;
      ramp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      fan_on_q   <= (duty_d != 8'd0);
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  // Next-state logic; exit from RAMP looks at the post-update duty so the
  // step that lands on the target also leaves RAMP in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (target != 8'd0) state_d = ST_RAMP;
      ST_RAMP: if (duty_d == target) state_d = (target != 8'd0) ? ST_RUN : ST_STOP;
      ST_RUN:  if (target != duty_q) state_d = ST_RAMP;
      default: state_d = ST_STOP;
    endcase
  end

  // Duty datapath and ramp prescaler; prescaler survives a mid-ramp target change.
  always_comb begin
    duty_d     = duty_q;
    ramp_cnt_d = '0;
    if (state_q == ST_RAMP) begin
      ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RW'(1);
      if (ramp_tick) begin
        if (duty_q < target)      duty_d = duty_q + 8'd1;
        else if (duty_q > target) duty_d = duty_q - 8'd1;
      end
    end else if (state_q == ST_STOP) begin
      duty_d = '0;
    end
  end

  // Off-timer
  assign count_en = (sel_q != 2'd0) && (stage_req != 2'd0);
  assign sec_tick = count_en && (sec_cnt_q == SW'(SEC_CYCLES - 1));
  assign sel_inc  = sel_q + 2'd1;

  always_comb begin
    sel_d     = sel_q;
    remain_d  = remain_q;
    timeout_d = timeout_q;
    sec_cnt_d = sec_cnt_q;
    if (count_en) sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SW'(1);
    // A button press outranks an expiry in the same cycle.
    if (timer_btn) begin
      sel_d     = sel_inc;
      sec_cnt_d = '0;
      timeout_d = 1'b0;
      case (sel_inc)
        2'd1:    remain_d = 15'd3600;
        2'd2:    remain_d = 15'd10800;
        2'd3:    remain_d = 15'd18000;
        default: remain_d = 15'd0;
      endcase
    end else begin
      if (stage_req == 2'd0) timeout_d = 1'b0;
      if (sec_tick) begin
        if (remain_q == 15'd1) begin
          remain_d  = '0;
          sel_d     = 2'd0;
          timeout_d = 1'b1;
        end else if (remain_q != 15'd0) begin
          remain_d = remain_q - 15'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= '0;
      remain_q  <= '0;
      timeout_q <= 1'b0;
      sec_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      remain_q  <= remain_d;
      timeout_q <= timeout_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign duty       = duty_q;
  assign fan_on     = fan_on_q;
  assign stage_eff  = stage_eff_w;
  assign timer_sel  = sel_q;
  assign remain_sec = remain_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_fan_duty_sequencer.sv
// tb_fan_duty_sequencer
//   Directed test of fan_duty_sequencer with SEC_CYCLES=10, RAMP_CYCLES=4.
module tb_fan_duty_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  stage_req;
  logic        timer_btn;
  logic [7:0]  duty;
  logic        fan_on;
  logic [1:0]  stage_eff;
  logic [1:0]  timer_sel;
  logic [14:0] remain_sec;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  fan_duty_sequencer #(
    .SEC_CYCLES (10),
    .RAMP_CYCLES(4),
    .DUTY_LOW   (33),
    .DUTY_HIGH  (66),
    .DUTY_MAX   (99)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stage_req (stage_req),
    .timer_btn (timer_btn),
    .duty      (duty),
    .fan_on    (fan_on),
    .stage_eff (stage_eff),
    .timer_sel (timer_sel),
    .remain_sec(remain_sec),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_duty(input string tag, input logic [7:0] v, input int budget);
    for (int i = 0; i < budget && duty !== v; i++) tick(1);
    check(tag, 32'(duty), 32'(v));
  endtask

  task automatic wait_remain(input string tag, input logic [14:0] v, input int budget);
    for (int i = 0; i < budget && remain_sec !== v; i++) tick(1);
    check(tag, 32'(remain_sec), 32'(v));
  endtask

  task automatic press;
    timer_btn = 1'b1;
    tick(1);
    timer_btn = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    stage_req = 2'd0;
    timer_btn = 1'b0;
    tick(3);
    check("rst_duty", 32'(duty), 0);
    check("rst_fan_on", 32'(fan_on), 0);
    check("rst_sel", 32'(timer_sel), 0);
    check("rst_remain", 32'(remain_sec), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Ramp up to LOW: one step every 4 clk
    reset_n   = 1'b1;
    stage_req = 2'd1;
    wait_duty("first_step", 8'd1, 20);
    check("fan_on_first_step", 32'(fan_on), 1);
    tick(3);
    check("step_hold", 32'(duty), 1);
    tick(1);
    check("second_step", 32'(duty), 2);
    tick(123);
    check("low_minus1", 32'(duty), 32);
    tick(1);
    check("low_reached", 32'(duty), 33);
    tick(10);
    check("low_hold", 32'(duty), 33);

    // Reverse mid-ramp at 50
    stage_req = 2'd3;
    wait_duty("up_to_50", 8'd50, 100);
    stage_req = 2'd1;
    tick(67);
    check("rev_34", 32'(duty), 34);
    tick(1);
    check("rev_33", 32'(duty), 33);
    tick(20);
    check("rev_hold", 32'(duty), 33);

    // Timer start at HIGH
    stage_req = 2'd2;
    wait_duty("high_reached", 8'd66, 200);
    press();
    check("sel_1h", 32'(timer_sel), 1);
    check("remain_3600", 32'(remain_sec), 3600);
    check("stage_eff_2", 32'(stage_eff), 2);
    tick(9);
    check("remain_pre_tick", 32'(remain_sec), 3600);
    tick(1);
    check("remain_3599", 32'(remain_sec), 3599);
    stage_req = 2'd0;
    tick(30);
    check("pause_remain", 32'(remain_sec), 3599);
    check("pause_sel", 32'(timer_sel), 1);
    stage_req = 2'd2;
    tick(10);
    check("resume_3598", 32'(remain_sec), 3598);

    // Expiry
    wait_remain("reach_1", 15'd1, 40000);
    check("duty_before_expiry", 32'(duty), 66);
    tick(9);
    check("pre_expiry_timeout", 32'(timeout), 0);
    check("pre_expiry_remain", 32'(remain_sec), 1);
    tick(1);
    check("expiry_timeout", 32'(timeout), 1);
    check("expiry_sel", 32'(timer_sel), 0);
    check("expiry_remain", 32'(remain_sec), 0);
    check("expiry_stage_eff", 32'(stage_eff), 0);
    tick(300);
    check("expired_duty", 32'(duty), 0);
    check("expired_fan_on", 32'(fan_on), 0);
    check("timeout_latched", 32'(timeout), 1);
    stage_req = 2'd0;
    tick(1);
    check("timeout_cleared", 32'(timeout), 0);

    // Button cycling
    press();
    check("cyc_sel1", 32'(timer_sel), 1);
    check("cyc_rem1", 32'(remain_sec), 3600);
    press();
    check("cyc_sel2", 32'(timer_sel), 2);
    check("cyc_rem2", 32'(remain_sec), 10800);
    press();
    check("cyc_sel3", 32'(timer_sel), 3);
    check("cyc_rem3", 32'(remain_sec), 18000);
    press();
    check("cyc_sel0", 32'(timer_sel), 0);
    check("cyc_rem0", 32'(remain_sec), 0);

    // Button on the expiry cycle wins
    press();
    stage_req = 2'd2;
    wait_remain("reach_1_again", 15'd1, 40000);
    tick(9);
    timer_btn = 1'b1;
    tick(1);
    timer_btn = 1'b0;
    check("btn_expiry_timeout", 32'(timeout), 0);
    check("btn_expiry_sel", 32'(timer_sel), 2);
    check("btn_expiry_remain", 32'(remain_sec), 10800);

    // Asynchronous reset mid-ramp
    stage_req = 2'd0;
    reset_n   = 1'b0;
    tick(1);
    reset_n   = 1'b1;
    press();
    stage_req = 2'd1;
    wait_duty("ramp_to_20", 8'd20, 200);
    check("pre_reset_sel", 32'(timer_sel), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_duty", 32'(duty), 0);
    check("async_fan_on", 32'(fan_on), 0);
    check("async_sel", 32'(timer_sel), 0);
    check("async_remain", 32'(remain_sec), 0);
    check("async_timeout", 32'(timeout), 0);
    tick(2);
    check("held_in_reset_duty", 32'(duty), 0);
    reset_n = 1'b1;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
